// File: rtl/uart_tx_sched_if.sv
// Byte-source handshake and transmitter control signals shared by uart_tx_sched.
// Handshake: a byte moves from source i on a rising clk edge where req_valid[i] & req_ready[i].
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_mask;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;

  modport master (
    output req_valid, req_data, req_mask, tx_busy,
    input  req_ready, tx_start, tx_data
  );

  modport slave (
    input  req_valid, req_data, req_mask, tx_busy,
    output req_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART byte transmitter among NUM_REQ sources,
// with a watchdog that abandons a frame the transmitter never acknowledges.
module uart_tx_sched #(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  uart_tx_sched_if.slave  bus,
  output logic [ID_W-1:0] cur_id,
  output logic            active,
  output logic            err_timeout,
  output logic [1:0]      dbg_state
);
  localparam int WDOG_W = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic              active_q, active_d;
  logic              err_q, err_d;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant_oh;
  logic [ID_W-1:0]    winner;
  logic [7:0]         win_data;
  logic               grant;

  // Search from cur_id+1 cyclically; the smallest offset is assigned last and wins.
  always_comb begin
    elig     = bus.req_valid & ~bus.req_mask;
    winner   = cur_id_q;
    win_data = 8'h00;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (elig[i] && (((int'(cur_id_q) + k) % NUM_REQ) == i)) begin
          winner = ID_W'(i);
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        win_data = bus.req_data[8*i +: 8];
      end
    end
    grant = (state_q == IDLE) && en && (|elig) && !bus.tx_busy;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_oh[i] = grant && (winner == ID_W'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    wdog_d    = wdog_q;
    tx_data_d = tx_data_q;
    cur_id_d  = cur_id_q;
    active_d  = active_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          tx_data_d = win_data;
          cur_id_d  = winner;
          active_d  = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (wdog_q == WDOG_W'(BUSY_TIMEOUT - 1)) begin
          // Byte is dropped; the round-robin pointer still moved on at grant time.
          err_d    = 1'b1;
          active_d = 1'b0;
          state_d  = IDLE;
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wdog_q    <= '0;
      tx_data_q <= 8'h00;
      cur_id_q  <= ID_W'(NUM_REQ - 1);
      active_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      tx_data_q <= tx_data_d;
      cur_id_q  <= cur_id_d;
      active_q  <= active_d;
      err_q     <= err_d;
    end
  end

  assign bus.req_ready = grant_oh;
  assign bus.tx_start  = (state_q == ISSUE);
  assign bus.tx_data   = tx_data_q;
  assign cur_id        = cur_id_q;
  assign active        = active_q;
  assign err_timeout   = err_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: reset-arbitration vector table, directed
// corner sequences, and randomized traffic against a frame-level reference model.
module tb_uart_tx_sched;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int BT      = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [ID_W-1:0] cur_id;
  logic            active;
  logic            err_timeout;
  logic [1:0]      dbg_state;

  uart_tx_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .BUSY_TIMEOUT(BT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .bus        (bus),
    .cur_id     (cur_id),
    .active     (active),
    .err_timeout(err_timeout),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // staged drive values, applied at each falling edge
  logic        drv_rst_n = 1'b0;
  logic        drv_en    = 1'b0;
  logic [3:0]  drv_valid = '0;
  logic [3:0]  drv_mask  = '0;
  logic [31:0] drv_data  = '0;
  logic        force_busy = 1'b0;

  // transmitter model
  logic tx_resp_en = 1'b0;
  logic rand_tx    = 1'b0;
  int   tx_dly = 1, tx_len = 4, dly_cnt = 0, busy_rem = 0;

  // observed outputs
  logic [3:0] o_ready;
  logic       o_start, o_active, o_err;
  logic [7:0] o_data;
  logic [1:0] o_id;

  // reference model / scoreboard
  logic       chk_on = 1'b0;
  logic       m_idle = 1'b1;
  int         m_last = NUM_REQ - 1;
  int         m_grant_cyc = -100, m_seen = -1, m_err_cyc = -1;
  logic [7:0] m_frame_data = '0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [3:0] el);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (last + k) % NUM_REQ;
      if (el[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [3:0] oh);
    for (int i = 0; i < NUM_REQ; i++) if (oh[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_idle = 1'b1;
    m_last = NUM_REQ - 1;
    m_grant_cyc = -100;
    m_seen = -1;
    m_err_cyc = -1;
    exp_q.delete();
  endtask

  // Frame-level expectations: a grant opens a frame, tx_start follows one cycle later,
  // the frame ends when busy falls after rising, or BT cycles after the start with no busy.
  task automatic model_cycle();
    logic [3:0] el, er;
    logic       exp_g;
    int         w;
    el    = drv_valid & ~drv_mask;
    exp_g = m_idle && drv_en && (el != 0) && !bus.tx_busy;
    w     = exp_g ? rr_pick(m_last, el) : -1;
    er    = exp_g ? (4'b0001 << w) : 4'b0000;
    check("req_ready", o_ready, er);
    check("tx_start", o_start, !m_idle && (cyc == m_grant_cyc + 1));
    check("active", o_active, !m_idle);
    check("err_timeout", o_err, cyc == m_err_cyc);
    check("cur_id", o_id, m_last);
    if (o_start) begin
      if (exp_q.size() == 0) check("tx_start_unexpected", 1, 0);
      else check("tx_data", o_data, exp_q.pop_front());
    end
    if (!m_idle && cyc > m_grant_cyc + 1) check("tx_data_hold", o_data, m_frame_data);
    if (exp_g) begin
      m_idle = 1'b0;
      m_grant_cyc = cyc;
      m_last = w;
      m_seen = -1;
      m_frame_data = drv_data[8*w +: 8];
      exp_q.push_back(m_frame_data);
    end else if (!m_idle) begin
      if (m_seen < 0) begin
        if (cyc >= m_grant_cyc + 2 && bus.tx_busy) m_seen = cyc;
        else if (cyc == m_grant_cyc + 1 + BT) begin
          m_idle = 1'b1;
          m_err_cyc = cyc + 1;
        end
      end else if (!bus.tx_busy) begin
        m_idle = 1'b1;
      end
    end
  endtask

  // driver: one clock cycle
  task automatic step();
    @(negedge clk);
    cyc++;
    rst_n         = drv_rst_n;
    en            = drv_en;
    bus.req_valid = drv_valid;
    bus.req_mask  = drv_mask;
    bus.req_data  = drv_data;
    if (dly_cnt > 0) begin
      dly_cnt--;
      if (dly_cnt == 0) busy_rem = tx_len;
    end
    bus.tx_busy = force_busy | (busy_rem > 0);
    if (busy_rem > 0) busy_rem--;
    #1;
    o_ready  = bus.req_ready;
    o_start  = bus.tx_start;
    o_data   = bus.tx_data;
    o_active = active;
    o_err    = err_timeout;
    o_id     = cur_id;
    if (chk_on) model_cycle();
    if (o_start && tx_resp_en) begin
      if (rand_tx) begin
        tx_dly = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
        tx_len = $urandom_range(1, 8);
      end
      if (tx_dly > 0) dly_cnt = tx_dly;
    end
  endtask

  task automatic do_reset();
    chk_on = 1'b0;
    drv_rst_n = 1'b0;
    step();
    step();
    model_reset();
    chk_on = 1'b1;
    drv_rst_n = 1'b1;
    step();
  endtask

  task automatic wait_grant(input int max_cyc, output int id);
    id = -1;
    for (int n = 0; n < max_cyc; n++) begin
      step();
      if (o_ready != 0) begin
        id = oh_idx(o_ready);
        return;
      end
    end
    check("grant_wait_expired", 0, 1);
  endtask

  typedef struct {
    logic       en;
    logic [3:0] valid;
    logic [3:0] mask;
    logic       busy;
    logic [3:0] exp_ready;
    int         exp_id;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int id, cnt_r, cnt_s, cnt_a, e_cyc, s_cyc, overlap;
    int order[6];
    int exp_order[6];
    logic [7:0] cap;

    rst_n = 1'b0; en = 1'b0;
    bus.req_valid = '0; bus.req_mask = '0; bus.req_data = '0; bus.tx_busy = 1'b0;

    // after reset cur_id = 3, so search order is 0,1,2,3
    vecs[0] = '{1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 0};
    vecs[1] = '{1'b1, 4'b0110, 4'b0100, 1'b0, 4'b0010, 1};
    vecs[2] = '{1'b1, 4'b1000, 4'b0000, 1'b0, 4'b1000, 3};
    vecs[3] = '{1'b1, 4'b1100, 4'b0000, 1'b0, 4'b0100, 2};
    vecs[4] = '{1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0000, 3};
    vecs[5] = '{1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0000, 3};
    vecs[6] = '{1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0000, 3};
    vecs[7] = '{1'b1, 4'b1010, 4'b0010, 1'b0, 4'b1000, 3};
    vecs[8] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3};
    vecs[9] = '{1'b1, 4'b1111, 4'b0001, 1'b0, 4'b0010, 1};

    // reset state
    step(); step();
    check("rst_req_ready", o_ready, 0);
    check("rst_tx_start", o_start, 0);
    check("rst_tx_data", o_data, 8'h00);
    check("rst_cur_id", o_id, NUM_REQ - 1);
    check("rst_active", o_active, 0);
    check("rst_err", o_err, 0);
    check("rst_state", dbg_state, 0);

    // vector table: each applied straight out of reset
    drv_data = 32'h44332211;
    for (int v = 0; v < 10; v++) begin
      drv_rst_n = 1'b0; drv_valid = '0; force_busy = 1'b0;
      step();
      drv_rst_n = 1'b1; drv_en = vecs[v].en; drv_valid = vecs[v].valid;
      drv_mask = vecs[v].mask; force_busy = vecs[v].busy;
      step();
      check($sformatf("vec%0d_ready", v), o_ready, vecs[v].exp_ready);
      step();
      check($sformatf("vec%0d_start", v), o_start, vecs[v].exp_ready != 0);
      check($sformatf("vec%0d_cur_id", v), o_id, vecs[v].exp_id);
      if (vecs[v].exp_ready != 0)
        check($sformatf("vec%0d_data", v), o_data, 8'h11 * (vecs[v].exp_id + 1));
    end
    drv_valid = '0; drv_mask = '0; force_busy = 1'b0; drv_en = 1'b1;
    do_reset();

    // single source, busy rises one cycle after tx_start and lasts 20 cycles
    tx_resp_en = 1'b1; tx_dly = 1; tx_len = 20;
    drv_valid = 4'b0001; drv_data = 32'h000000A5;
    cnt_r = 0; cnt_s = 0; cnt_a = 0; cap = 8'h00;
    for (int n = 0; n < 40; n++) begin
      step();
      if (o_ready != 0) begin cnt_r++; drv_valid = '0; end
      if (o_start) begin cnt_s++; cap = o_data; end
      if (o_active) cnt_a++;
    end
    check("single_ready_pulses", cnt_r, 1);
    check("single_start_pulses", cnt_s, 1);
    check("single_tx_data", cap, 8'hA5);
    check("single_active_cycles", cnt_a, 22);

    // fairness from reset: 0,1,2,3,0,1
    do_reset();
    tx_len = 5; drv_valid = 4'b1111; drv_data = 32'hD4C3B2A1; overlap = 0;
    exp_order = '{0, 1, 2, 3, 0, 1};
    for (int g = 0; g < 6; g++) begin
      order[g] = -1;
      for (int n = 0; n < 40 && order[g] < 0; n++) begin
        step();
        if (o_start && bus.tx_busy) overlap++;
        if (o_ready != 0) order[g] = oh_idx(o_ready);
      end
      check($sformatf("fair_grant%0d", g), order[g], exp_order[g]);
    end
    check("fair_start_in_busy", overlap, 0);

    // mask: only source 1 eligible
    drv_valid = 4'b0110; drv_mask = 4'b0100; tx_len = 3;
    for (int g = 0; g < 3; g++) begin
      wait_grant(40, id);
      check("mask_grant_id", id, 1);
    end
    drv_valid = '0; drv_mask = '0;
    for (int n = 0; n < 20; n++) step();

    // enable low: nothing granted for 50 cycles
    drv_en = 1'b0; drv_valid = 4'b1111; cnt_r = 0; cnt_s = 0;
    for (int n = 0; n < 50; n++) begin
      step();
      if (o_ready != 0) cnt_r++;
      if (o_start) cnt_s++;
    end
    check("en0_ready", cnt_r, 0);
    check("en0_start", cnt_s, 0);
    drv_en = 1'b1; drv_valid = '0;

    // watchdog: transmitter never answers
    do_reset();
    tx_resp_en = 1'b0; drv_valid = 4'b0001; s_cyc = -1; e_cyc = -1;
    wait_grant(10, id);
    drv_valid = '0;
    for (int n = 0; n < 40 && e_cyc < 0; n++) begin
      step();
      if (o_start) s_cyc = cyc;
      if (o_err) begin
        e_cyc = cyc;
        check("wdog_active_at_err", o_active, 0);
      end
    end
    check("wdog_err_delay", e_cyc - (s_cyc + 1), BT);
    drv_valid = 4'b0011;
    wait_grant(10, id);
    check("wdog_next_grant", id, 1);
    drv_valid = '0;
    for (int n = 0; n < 30; n++) step();
    tx_resp_en = 1'b1; tx_dly = 1; tx_len = 4;

    // foreign busy blocks grants; release grants in the cycle busy is low
    drv_valid = 4'b0100; force_busy = 1'b1; cnt_r = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (o_ready != 0) cnt_r++;
    end
    check("foreign_busy_ready", cnt_r, 0);
    force_busy = 1'b0;
    step();
    check("foreign_release_grant", o_ready, 4'b0100);
    drv_valid = '0;
    for (int n = 0; n < 20; n++) step();

    // reset during WAIT_DONE
    tx_len = 20; drv_valid = 4'b1000;
    wait_grant(10, id);
    drv_valid = '0;
    for (int n = 0; n < 10; n++) step();
    check("midrst_in_frame", o_active && bus.tx_busy, 1);
    #1 rst_n = 1'b0;
    chk_on = 1'b0;
    #1;
    check("midrst_ready", bus.req_ready, 0);
    check("midrst_start", bus.tx_start, 0);
    check("midrst_data", bus.tx_data, 8'h00);
    check("midrst_cur_id", cur_id, NUM_REQ - 1);
    check("midrst_active", active, 0);
    check("midrst_err", err_timeout, 0);
    drv_rst_n = 1'b0;
    step();
    model_reset();
    chk_on = 1'b1;
    drv_rst_n = 1'b1; drv_valid = 4'b1111; drv_data = 32'h99887766;
    wait_grant(40, id);
    check("midrst_first_grant", id, 0);
    drv_valid = '0;
    for (int n = 0; n < 40; n++) step();

    // randomized traffic against the reference model
    do_reset();
    rand_tx = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      drv_valid  = 4'($urandom_range(0, 15));
      drv_mask   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      drv_en     = ($urandom_range(0, 9) != 0);
      drv_data   = $urandom;
      force_busy = ($urandom_range(0, 49) == 0);
      step();
    end
    drv_valid = '0; force_busy = 1'b0; drv_en = 1'b1;
    for (int n = 0; n < 60; n++) step();
    check("rand_queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one UART transmitter (the tx_start / tx_data / tx_busy byte-serialiser in the APB UART IP) among NUM_REQ byte sources. Each source offers bytes over a valid/ready handshake. The scheduler grants one source at a time, launches exactly one transmitter frame per accepted byte, and tracks the frame to completion before granting again. A watchdog recovers if the transmitter never acknowledges a start.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of grant index; must satisfy 2**ID_W >= NUM_REQ
BUSY_TIMEOUT, 16, max clk cycles to wait for tx_busy to rise after tx_start (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
en  in  1  scheduler enable; 0 blocks new grants, never aborts a frame in flight
req_valid  in  NUM_REQ  per-source byte available
req_data  in  NUM_REQ*8  per-source byte; source i occupies bits [8i+7:8i]
req_mask  in  NUM_REQ  1 = source excluded from arbitration
req_ready  out  NUM_REQ  one-hot accept; transfer when req_valid[i] & req_ready[i]
tx_start  out  1  one-cycle launch pulse to transmitter
tx_data  out  8  byte to transmitter, stable from tx_start until frame done
tx_busy  in  1  transmitter busy flag
cur_id  out  ID_W  index of last/active granted source
active  out  1  1 while a frame is being issued or is in flight
err_timeout  out  1  one-cycle pulse when watchdog expires

Behaviour:
- Reset: req_ready=0, tx_start=0, tx_data=8'h00, cur_id=NUM_REQ-1, active=0, err_timeout=0, state=IDLE, wdog=0. Reset mid-frame returns immediately to IDLE; the transmitter's own reset is separate.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- Eligible vector: elig = req_valid & ~req_mask.
- IDLE: if en & |elig & !tx_busy, the winner is the first set bit of elig searching cyclically from cur_id+1 (wraps NUM_REQ-1 -> 0). req_ready[winner]=1 combinationally in this cycle only; all other bits are 0. On the clock edge: latch tx_data <= winner byte, cur_id <= winner, active <= 1, go to ISSUE. Otherwise stay in IDLE with req_ready=0. If tx_busy=1 in IDLE (e.g. a foreign user), no grant is made.
- ISSUE: tx_start=1 for exactly this cycle (registered, high only while state==ISSUE); go to WAIT_BUSY with wdog cleared.
- WAIT_BUSY: if tx_busy=1, go to WAIT_DONE. Else wdog increments. When wdog==BUSY_TIMEOUT-1 with tx_busy still 0: pulse err_timeout for 1 cycle, set active=0, go to IDLE (the byte is dropped; no retry).
- WAIT_DONE: on tx_busy=0, set active=0 and go to IDLE. Earliest next grant is the cycle after return to IDLE, which guarantees tx_busy is sampled low.
- Latency: handshake cycle T -> tx_start high in cycle T+1 -> tx_busy expected at T+2.
- Throughput: at most one byte per frame. A source holding req_valid continuously gets one grant per round when others compete.
- req_ready never asserts outside IDLE. Changes to req_mask or en outside IDLE have no effect until the next IDLE.
- cur_id updates only on a grant; err_timeout does not alter the round-robin pointer advance.
- wdog width is clog2(BUSY_TIMEOUT)+1; it saturates and never wraps.

Test Plan:
- Single source: en=1, req_valid=4'b0001, data 8'hA5, tx_busy model rises 1 cycle after tx_start and lasts 20 cycles -> req_ready[0] pulses once, tx_start one cycle, tx_data=8'hA5, active high ~22 cycles, then back to IDLE.
- Fairness: all four sources valid continuously after reset (cur_id=3) -> grant order 0,1,2,3,0,1; exactly one req_ready bit per frame, never two tx_start pulses within one tx_busy window.
- Mask/enable: req_valid=4'b0110, req_mask=4'b0100 -> only source 1 granted. With en=0 and requests pending -> no req_ready or tx_start for 50 cycles.
- Watchdog: tx_busy tied 0 with BUSY_TIMEOUT=16 -> err_timeout pulses exactly 16 cycles after entering WAIT_BUSY, active drops, the next grant proceeds to the next source.
- Foreign busy: tx_busy=1 while idle and requests pending -> no grant. Release tx_busy -> grant in the following cycle.
- Reset mid-frame: assert rst_n=0 during WAIT_DONE -> all outputs return to reset values asynchronously; after release, arbitration restarts at source 0.
